dma_copy: RTL and testbench

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_copy.sv | 174 +++++++++++++++++
 tb/tb_dma_copy.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the word-copy DMA engine: FSM states, slave
// register offsets and the byte-lane merge used by the register writes.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_t;

  // Register index taken from address bits [3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Address increment per copied 32-bit word
  localparam logic [31:0] WORD_STEP = 32'd4;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = mask[b] ? new_value[8*b +: 8] : old_value[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// Memory-to-memory word copier. A zero-wait slave port holds the SRC, DST,
// LEN and CTRL registers; a master port performs one read then one write per
// word until LEN reaches zero or the bus reports a fault.
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in
);

  dma_state_t           r_state;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_len;
  logic [31:0]          r_data;
  logic                 r_done;
  logic                 r_fault;
  logic [31:0]          r_address_out;
  logic                 r_read_out;
  logic                 r_write_out;
  logic [3:0]           r_write_mask_out;

  logic [1:0]  w_reg_sel;
  logic        w_busy;
  logic        w_wr_en;
  logic        w_start;
  logic        w_len_zero;
  logic        w_len_one;
  logic [31:0] w_len_ext;
  logic [31:0] w_src_merged;
  logic [31:0] w_dst_merged;
  logic [31:0] w_len_merged;
  logic [31:0] w_read_mux;
  logic        w_unused;

  // Any asserted byte enable on a selected access is a register write
  assign w_reg_sel  = address_in[3:2];
  assign w_busy     = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_wr_en    = sel_in && (write_mask_in != 4'b0000);
  assign w_start    = w_wr_en && (w_reg_sel == REG_CTRL) && write_mask_in[0] && write_value_in[0];
  assign w_len_zero = (r_len == '0);
  assign w_len_one  = (r_len == LEN_WIDTH'(1));
  assign w_len_ext  = 32'(r_len);

  // Word-aligned pointers: the two low address bits never hold a 1
  assign w_src_merged = merge_bytes(r_src, write_value_in, write_mask_in) & ~32'h3;
  assign w_dst_merged = merge_bytes(r_dst, write_value_in, write_mask_in) & ~32'h3;
  assign w_len_merged = merge_bytes(w_len_ext, write_value_in, write_mask_in);

  // Only address bits [3:2] decode registers; the rest alias, and reads need
  // no strobe because the data path is combinational
  assign w_unused = ^{address_in[31:4], address_in[1:0], read_in, w_len_merged};

  // Slave read data selection
  always_comb begin
    w_read_mux = 32'h0;
    case (w_reg_sel)
      REG_SRC: w_read_mux = r_src;
      REG_DST: w_read_mux = r_dst;
      REG_LEN: w_read_mux = w_len_ext;
      default: w_read_mux = {29'h0, r_fault, r_done, w_busy};
    endcase
  end

  // Wired-OR slave bus: drive zero whenever not selected or held in reset
  assign read_value_out  = (sel_in && reset_n) ? w_read_mux : 32'h0;
  assign ready_out       = sel_in;
  assign address_out     = r_address_out;
  assign read_out        = r_read_out;
  assign write_out       = r_write_out;
  assign write_mask_out  = r_write_mask_out;
  assign write_value_out = r_data;

  // Register file updates plus the copy FSM with registered master requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_src            <= 32'h0;
      r_dst            <= 32'h0;
      r_len            <= '0;
      r_data           <= 32'h0;
      r_done           <= 1'b0;
      r_fault          <= 1'b0;
      r_address_out    <= 32'h0;
      r_read_out       <= 1'b0;
      r_write_out      <= 1'b0;
      r_write_mask_out <= 4'h0;
    end else begin
      if (w_wr_en && !w_busy) begin
        case (w_reg_sel)
          REG_SRC: r_src <= w_src_merged;
          REG_DST: r_dst <= w_dst_merged;
          REG_LEN: r_len <= w_len_merged[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_fault <= 1'b0;
            if (w_len_zero) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_done        <= 1'b0;
              r_read_out    <= 1'b1;
              r_address_out <= r_src;
              r_state       <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (ready_in) begin
            r_read_out <= 1'b0;
            if (fault_in) begin
              r_fault <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_data           <= read_value_in;
              r_write_out      <= 1'b1;
              r_write_mask_out <= 4'hF;
              r_address_out    <= r_dst;
              r_state          <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (ready_in) begin
            r_write_out      <= 1'b0;
            r_write_mask_out <= 4'h0;
            if (fault_in) begin
              r_fault <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_src <= r_src + WORD_STEP;
              r_dst <= r_dst + WORD_STEP;
              r_len <= r_len - LEN_WIDTH'(1);
              if (w_len_one) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_read_out    <= 1'b1;
                r_address_out <= r_src + WORD_STEP;
                r_state       <= ST_RD;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: directed register programming, a memory
// model with configurable wait states and fault injection, and a monitor that
// checks every master handshake and slave read against queued expectations.
`timescale 1ns/1ps
module tb_dma_copy;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .address_out    (address_out),
    .read_out       (read_out),
    .write_out      (write_out),
    .write_mask_out (write_mask_out),
    .write_value_out(write_value_out),
    .read_value_in  (read_value_in),
    .ready_in       (ready_in),
    .fault_in       (fault_in)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] src_mem [logic [31:0]];
  logic [31:0] dst_mem [logic [31:0]];
  int mem_waits = 0;
  int fault_at  = 0;
  int rd_cnt    = 0;
  bit chk_stable = 1'b0;

  logic [31:0] exp_mrd_addr[$];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [31:0] exp_rd_val[$];
  string       exp_rd_tag[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] rsel, input logic [31:0] val, input logic [3:0] mask);
    sel_in = 1'b1; read_in = 1'b0;
    address_in = {28'h0, rsel, 2'b00};
    write_mask_in = mask; write_value_in = val;
    @(negedge clk);
    sel_in = 1'b0; write_mask_in = 4'h0; write_value_in = 32'h0; address_in = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] rsel, input logic [31:0] exp, input string tag);
    exp_rd_val.push_back(exp);
    exp_rd_tag.push_back(tag);
    sel_in = 1'b1; read_in = 1'b1; write_mask_in = 4'h0;
    address_in = {28'h0, rsel, 2'b00};
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
  endtask

  task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst);
    exp_mrd_addr.push_back(src);
    exp_wr_addr.push_back(dst);
    exp_wr_data.push_back(src_mem[src]);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!read_out && !write_out) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 2) begin
      failures++;
      $display("FAIL %s_timeout: still requesting after %0d cycles, required idle", tag, cyc);
    end
  endtask

  task automatic check_drained(input string tag);
    check32({tag, "_mrd_left"}, 32'(exp_mrd_addr.size()), 32'd0);
    check32({tag, "_mwr_left"}, 32'(exp_wr_addr.size()), 32'd0);
  endtask

  // Memory model: wait states, read data from src_mem, writes into dst_mem
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ready_in = 1'b0; fault_in = 1'b0; read_value_in = 32'h0;
    forever begin
      @(negedge clk);
      ready_in = 1'b0; fault_in = 1'b0;
      if (!reset_n || !(read_out || write_out)) begin
        wait_cnt = 0;
      end else if (wait_cnt < mem_waits) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        ready_in = 1'b1;
        if (read_out) begin
          rd_cnt++;
          read_value_in = src_mem.exists(address_out) ? src_mem[address_out] : 32'hDEAD0000;
          if (fault_at != 0 && rd_cnt == fault_at) fault_in = 1'b1;
        end else begin
          dst_mem[address_out] = write_value_out;
        end
      end
    end
  end

  // Monitor: pops expectations on every master handshake and slave read
  initial begin
    logic [31:0] prev_addr;
    logic prev_rd, prev_wr, prev_pending;
    prev_pending = 1'b0; prev_addr = 32'h0; prev_rd = 1'b0; prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_pending = 1'b0;
      end else begin
        if (read_out || write_out)
          check32("rd_wr_exclusive", 32'(read_out & write_out), 32'd0);
        if (chk_stable && prev_pending) begin
          check32("hold_addr", address_out, prev_addr);
          check32("hold_req", {30'h0, read_out, write_out}, {30'h0, prev_rd, prev_wr});
        end
        prev_pending = (read_out || write_out) && !ready_in;
        prev_addr = address_out; prev_rd = read_out; prev_wr = write_out;

        if (read_out && ready_in) begin
          if (exp_mrd_addr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mrd: got read at 0x%08h required none", address_out);
          end else begin
            check32("mrd_addr", address_out, exp_mrd_addr.pop_front());
            $display("master read  addr=0x%08h fault=%0b", address_out, fault_in);
          end
        end
        if (write_out && ready_in) begin
          if (exp_wr_addr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mwr: got write at 0x%08h required none", address_out);
          end else begin
            check32("mwr_addr", address_out, exp_wr_addr.pop_front());
            check32("mwr_data", write_value_out, exp_wr_data.pop_front());
            check32("mwr_mask", {28'h0, write_mask_out}, 32'hF);
            $display("master write addr=0x%08h data=0x%08h", address_out, write_value_out);
          end
        end
        if (sel_in && read_in) begin
          check32("ready_eq_sel", 32'(ready_out), 32'd1);
          if (exp_rd_val.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_slave_read: got 0x%08h required no read", read_value_out);
          end else begin
            string tag;
            tag = exp_rd_tag.pop_front();
            check32(tag, read_value_out, exp_rd_val.pop_front());
            $display("slave read %s data=0x%08h", tag, read_value_out);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    bit seen;
    reset_n = 1'b0; sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
    write_mask_in = 4'h0; write_value_in = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check32("rst_master_req", {28'h0, read_out, write_out, 2'b00} | {28'h0, write_mask_out}, 32'h0);
    sel_in = 1'b1; read_in = 1'b1; address_in = {28'h0, REG_CTRL, 2'b00};
    #1 check32("rst_read_value", read_value_out, 32'h0);
    sel_in = 1'b0; read_in = 1'b0; address_in = 32'h0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    bus_read(REG_SRC,  32'h0, "rst_src");
    bus_read(REG_DST,  32'h0, "rst_dst");
    bus_read(REG_LEN,  32'h0, "rst_len");
    bus_read(REG_CTRL, 32'h0, "rst_ctrl");
    check32("unselected_read_zero", read_value_out, 32'h0);

    // Byte-masked register writes and pointer alignment
    bus_write(REG_SRC, 32'h12345677, 4'hF);
    bus_read(REG_SRC, 32'h12345674, "src_full_mask");
    bus_write(REG_SRC, 32'h0000AB00, 4'b0010);
    bus_read(REG_SRC, 32'h1234AB74, "src_byte1");
    bus_write(REG_DST, 32'hFFFFFFFF, 4'hF);
    bus_read(REG_DST, 32'hFFFFFFFC, "dst_align");
    bus_write(REG_LEN, 32'hFFFF0105, 4'b0001);
    bus_read(REG_LEN, 32'h00000005, "len_byte0");
    bus_write(REG_LEN, 32'h00FF0000, 4'b0100);
    bus_read(REG_LEN, 32'h00000005, "len_width");

    // Start bit with its byte lane disabled does nothing
    bus_write(REG_CTRL, 32'h1, 4'b0010);
    check32("start_mask_off", 32'(read_out), 32'd0);

    // LEN=0: done the cycle after start, no master traffic
    bus_write(REG_LEN, 32'h0, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    bus_read(REG_CTRL, 32'h2, "len0_done_next_cycle");
    for (int i = 0; i < 5; i++) begin
      check32("len0_no_req", {30'h0, read_out, write_out}, 32'h0);
      @(negedge clk);
    end

    // Three-word copy with zero-wait memory
    src_mem[32'h100] = 32'hA0A00001;
    src_mem[32'h104] = 32'hB0B00002;
    src_mem[32'h108] = 32'hC0C00003;
    bus_write(REG_SRC, 32'h100, 4'hF);
    bus_write(REG_DST, 32'h200, 4'hF);
    bus_write(REG_LEN, 32'd3, 4'hF);
    expect_copy(32'h100, 32'h200);
    expect_copy(32'h104, 32'h204);
    expect_copy(32'h108, 32'h208);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    check32("start_to_read_1cyc", 32'(read_out), 32'd1);
    check32("first_rd_addr", address_out, 32'h100);
    bus_read(REG_CTRL, 32'h1, "busy_status");
    wait_idle("copy3");
    bus_read(REG_CTRL, 32'h2, "copy3_status");
    bus_read(REG_LEN,  32'h0, "copy3_len");
    bus_read(REG_SRC,  32'h10C, "copy3_src");
    bus_read(REG_DST,  32'h20C, "copy3_dst");
    check_drained("copy3");

    // Two wait states: requests must hold steady until ready
    mem_waits = 2; chk_stable = 1'b1;
    src_mem[32'h300] = 32'h12345678;
    src_mem[32'h304] = 32'h9ABCDEF0;
    bus_write(REG_SRC, 32'h300, 4'hF);
    bus_write(REG_DST, 32'h400, 4'hF);
    bus_write(REG_LEN, 32'd2, 4'hF);
    expect_copy(32'h300, 32'h400);
    expect_copy(32'h304, 32'h404);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    wait_idle("waitstate");
    chk_stable = 1'b0; mem_waits = 0;
    check32("ws_mem0", dst_mem[32'h400], 32'h12345678);
    check32("ws_mem1", dst_mem[32'h404], 32'h9ABCDEF0);
    bus_read(REG_CTRL, 32'h2, "ws_status");
    check_drained("waitstate");

    // Fault on the second read of a four-word copy
    src_mem[32'h500] = 32'h55000000;
    src_mem[32'h504] = 32'h55000004;
    src_mem[32'h508] = 32'h55000008;
    src_mem[32'h50C] = 32'h5500000C;
    bus_write(REG_SRC, 32'h500, 4'hF);
    bus_write(REG_DST, 32'h600, 4'hF);
    bus_write(REG_LEN, 32'd4, 4'hF);
    fault_at = rd_cnt + 2;
    expect_copy(32'h500, 32'h600);
    exp_mrd_addr.push_back(32'h504);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    wait_idle("fault");
    fault_at = 0;
    bus_read(REG_CTRL, 32'h6, "fault_status");
    bus_read(REG_SRC,  32'h504, "fault_src");
    bus_read(REG_DST,  32'h604, "fault_dst");
    bus_read(REG_LEN,  32'd3, "fault_len");
    check_drained("fault");

    // Restart resumes the remaining words and clears fault/done
    expect_copy(32'h504, 32'h604);
    expect_copy(32'h508, 32'h608);
    expect_copy(32'h50C, 32'h60C);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    bus_read(REG_CTRL, 32'h1, "restart_clears_status");
    wait_idle("restart");
    bus_read(REG_CTRL, 32'h2, "restart_status");
    bus_read(REG_LEN,  32'h0, "restart_len");
    check_drained("restart");

    // DST wrap, plus writes and a second start while busy
    mem_waits = 2;
    src_mem[32'h700] = 32'h77770000;
    src_mem[32'h704] = 32'h77770004;
    bus_write(REG_SRC, 32'h700, 4'hF);
    bus_write(REG_DST, 32'hFFFFFFFC, 4'hF);
    bus_write(REG_LEN, 32'd2, 4'hF);
    expect_copy(32'h700, 32'hFFFFFFFC);
    expect_copy(32'h704, 32'h00000000);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    bus_write(REG_SRC, 32'h900, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    bus_write(REG_LEN, 32'd9, 4'hF);
    bus_write(REG_DST, 32'h40, 4'hF);
    wait_idle("wrap");
    mem_waits = 0;
    bus_read(REG_SRC,  32'h708, "wrap_src");
    bus_read(REG_DST,  32'h4, "wrap_dst");
    bus_read(REG_LEN,  32'h0, "wrap_len");
    bus_read(REG_CTRL, 32'h2, "wrap_status");
    check_drained("wrap");

    // Reset asserted in the middle of a write
    mem_waits = 3;
    src_mem[32'h800] = 32'h88880000;
    bus_write(REG_SRC, 32'h800, 4'hF);
    bus_write(REG_DST, 32'hA00, 4'hF);
    bus_write(REG_LEN, 32'd2, 4'hF);
    exp_mrd_addr.push_back(32'h800);
    bus_write(REG_CTRL, 32'h1, 4'h1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (write_out) seen = 1'b1;
    end
    check32("midwr_reached", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check32("midwr_write_drop", 32'(write_out), 32'd0);
    check32("midwr_req_low", {28'h0, write_mask_out} | {31'h0, read_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_waits = 0;
    @(negedge clk);
    check32("midwr_no_commit", 32'(dst_mem.exists(32'hA00)), 32'd0);
    bus_read(REG_SRC,  32'h0, "post_rst_src");
    bus_read(REG_DST,  32'h0, "post_rst_dst");
    bus_read(REG_LEN,  32'h0, "post_rst_len");
    bus_read(REG_CTRL, 32'h0, "post_rst_ctrl");
    check_drained("midwr");
    check32("slave_reads_left", 32'(exp_rd_val.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
